// File: rtl/tile_pkg.sv
// ---------------------------------------------------------------------------
// tile_pkg
// Shared definitions for the tile texture fetch path:
//   - tile_id_e   : the eight tile sprite ids
//   - TILE_W      : sprite edge length in pixels (16x16 sprites)
//   - color_t     : 6-bit palette index
//   - arb_state_e : arbiter state (IDLE / LOCKED)
//   - sprite_pixel / sprite_rom : sprite artwork, evaluated at elaboration
//     time to build one constant ROM image per tile
// ---------------------------------------------------------------------------
package tile_pkg;

    localparam int TILE_W       = 16;
    localparam int COLOR_W      = 6;
    localparam int NUM_TILE_IDS = 8;
    localparam int ROM_BITS     = TILE_W * TILE_W * COLOR_W;

    typedef logic [COLOR_W-1:0] color_t;

    typedef enum logic [2:0] {
        EMPTY,
        BRICK,
        STEEL,
        WATER,
        TREE,
        ICE,
        BASE,
        BORDER
    } tile_id_e;

    typedef enum logic [0:0] {
        IDLE,
        LOCKED
    } arb_state_e;

    // Sprite artwork. Each tile is described procedurally so the ROM images
    // stay readable; the values are palette indices.
    //   EMPTY  : all 0
    //   BRICK  : running-bond bricks (9) with mortar (8) every 4th row and a
    //            vertical joint at column 7 / 3 on alternating courses
    //   STEEL  : rim 4, rivets 5 at (2|13, 2|13), 4x4 checker of 1 / 2 inside
    //   WATER  : 13 on every 4th anti-diagonal, else 12
    //   TREE   : checkerboard 20 / 21
    //   ICE    : both diagonals 30, else 31
    //   BASE   : central 8x8 emblem 40 on 41
    //   BORDER : rim 50, inside 51
    function automatic color_t sprite_pixel(input logic [2:0] tile, input int x, input int y);
        color_t p;
        logic   on_rim;
        int     joint_col;
        on_rim    = (x == 0) || (y == 0) || (x == TILE_W - 1) || (y == TILE_W - 1);
        joint_col = ((y % 8) < 4) ? 7 : 3;
        p         = '0;
        case (tile_id_e'(tile))
            EMPTY:  p = 6'd0;
            BRICK:  p = (((y % 4) == 3) || ((x % 8) == joint_col)) ? 6'd8 : 6'd9;
            STEEL: begin
                if (on_rim)
                    p = 6'd4;
                else if (((x == 2) || (x == 13)) && ((y == 2) || (y == 13)))
                    p = 6'd5;
                else if ((((x / 4) + (y / 4)) % 2) == 1)
                    p = 6'd1;
                else
                    p = 6'd2;
            end
            WATER:  p = (((x + y) % 4) == 0) ? 6'd13 : 6'd12;
            TREE:   p = (((x + y) % 2) == 1) ? 6'd20 : 6'd21;
            ICE:    p = ((x == y) || ((x + y) == TILE_W - 1)) ? 6'd30 : 6'd31;
            BASE:   p = ((x >= 4) && (x <= 11) && (y >= 4) && (y <= 11)) ? 6'd40 : 6'd41;
            BORDER: p = on_rim ? 6'd50 : 6'd51;
            default: p = 6'd0;
        endcase
        return p;
    endfunction

    // Flattened ROM image: pixel (x, y) lives at bit offset ((y*16)+x)*6.
    function automatic logic [ROM_BITS-1:0] sprite_rom(input logic [2:0] tile);
        logic [ROM_BITS-1:0] rom;
        rom = '0;
        for (int y = 0; y < TILE_W; y++) begin
            for (int x = 0; x < TILE_W; x++) begin
                rom[((y * TILE_W) + x) * COLOR_W +: COLOR_W] = sprite_pixel(tile, x, y);
            end
        end
        return rom;
    endfunction

endpackage

// File: rtl/tile_fetch_arbiter_if.sv
// ---------------------------------------------------------------------------
// tile_fetch_arbiter_if
// Request/response bundle between NUM_REQ requesters and the tile fetch
// arbiter.
//   req_valid[i]  : requester i wants a lookup
//   req_lock[i]   : requester i wants to hold the grant for a row burst
//   req_tile[i]   : tile id (3 bits)
//   req_x/req_y[i]: pixel column / row inside the 16x16 tile
//   req_ready     : one-hot grant (combinational in the arbiter)
//   rsp_valid     : one-hot response strobe, one cycle after acceptance
//   rsp_color     : palette index of the looked-up pixel
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface tile_fetch_arbiter_if
    import tile_pkg::*;
#(
    parameter int NUM_REQ = 4
);

    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_lock;
    logic [NUM_REQ-1:0][2:0] req_tile;
    logic [NUM_REQ-1:0][3:0] req_x;
    logic [NUM_REQ-1:0][3:0] req_y;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ-1:0]      rsp_valid;
    color_t                  rsp_color;

    modport master (
        output req_valid,
        output req_lock,
        output req_tile,
        output req_x,
        output req_y,
        input  req_ready,
        input  rsp_valid,
        input  rsp_color
    );

    modport slave (
        input  req_valid,
        input  req_lock,
        input  req_tile,
        input  req_x,
        input  req_y,
        output req_ready,
        output rsp_valid,
        output rsp_color
    );

endinterface

// File: rtl/tile_rom_mux.sv
// ---------------------------------------------------------------------------
// tile_rom_mux
// Holds one constant 16x16 sprite ROM per tile id and selects a pixel by
// tile id, column and row, purely combinationally. Tile ids at or above
// NUM_TILES have no ROM and read as palette index 0.
// Ports:
//   tile_i  : tile id
//   x_i     : pixel column (0..15)
//   y_i     : pixel row    (0..15)
//   color_o : palette index
// ---------------------------------------------------------------------------
module tile_rom_mux
    import tile_pkg::*;
#(
    parameter int NUM_TILES = 8
) (
    input  logic [2:0] tile_i,
    input  logic [3:0] x_i,
    input  logic [3:0] y_i,
    output color_t     color_o
);

    localparam int BASE_W = $clog2(ROM_BITS);

    color_t            pix [NUM_TILE_IDS];
    logic [BASE_W-1:0] pix_base;

    // Bit offset of pixel (x, y) inside every flattened ROM image.
    assign pix_base = BASE_W'({y_i, x_i}) * BASE_W'(COLOR_W);

    generate
        for (genvar gi = 0; gi < NUM_TILE_IDS; gi++) begin : g_rom
            if (gi < NUM_TILES) begin : g_sprite
                localparam logic [ROM_BITS-1:0] ROM = sprite_rom(3'(gi));
                assign pix[gi] = ROM[pix_base +: COLOR_W];
            end else begin : g_absent
                assign pix[gi] = '0;
            end
        end
    endgenerate

    assign color_o = pix[tile_i];

endmodule

// File: rtl/tile_fetch_arbiter.sv
// ---------------------------------------------------------------------------
// tile_fetch_arbiter
// Shares one tile-texture lookup between NUM_REQ requesters.
//   IDLE   : round-robin grant starting at rr_ptr.
//   LOCKED : a requester that was accepted with req_lock high owns the port
//            for up to 16 further accepted lookups (lock_cnt 15..0); the
//            burst ends when the owner is accepted at lock_cnt 0 or drops
//            req_lock. While the owner is not valid nobody is granted.
// Responses are registered: rsp_valid/rsp_color appear one cycle after the
// acceptance, and rsp_color holds its value between responses.
// Build option: define TILE_ARB_PRIO0_EN to give requester 0 (display path)
// absolute priority in IDLE; locked bursts are still honoured.
// Ports:
//   Clk       : clock, rising edge
//   Reset     : asynchronous, active-high reset
//   bus       : tile_fetch_arbiter_if slave modport (requests / responses)
//   busy_lock : high while the arbiter is LOCKED
// ---------------------------------------------------------------------------
module tile_fetch_arbiter
    import tile_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int NUM_TILES = 8
) (
    input  logic                 Clk,
    input  logic                 Reset,
    tile_fetch_arbiter_if.slave  bus,
    output logic                 busy_lock
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [0:0] ST_IDLE   = IDLE;
    localparam logic [0:0] ST_LOCKED = LOCKED;

    logic [0:0]         state_q,    state_d;
    logic [PTR_W-1:0]   rr_ptr_q,   rr_ptr_d;
    logic [PTR_W-1:0]   owner_q,    owner_d;
    logic [3:0]         lock_cnt_q, lock_cnt_d;
    logic [NUM_REQ-1:0] rsp_valid_q;
    color_t             rsp_color_q;

    logic [NUM_REQ-1:0] grant;
    logic [PTR_W-1:0]   grant_idx;
    logic               accept_any;
    logic               rr_found;
    logic [PTR_W-1:0]   rr_idx;
    logic [2:0]         sel_tile;
    logic [3:0]         sel_x;
    logic [3:0]         sel_y;
    color_t             rom_color;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(NUM_REQ - 1))
            return '0;
        return p + PTR_W'(1);
    endfunction

    // Round-robin search: first valid requester at or after rr_ptr.
    always_comb begin : p_rr_search
        logic [PTR_W-1:0] cand;
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = rr_ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!rr_found && bus.req_valid[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
            cand = ptr_inc(cand);
        end
    end

    // Grant selection. grant only ever has a bit set for a valid requester,
    // so every grant is also an acceptance.
    always_comb begin : p_grant
        grant     = '0;
        grant_idx = '0;
        if (state_q == ST_LOCKED) begin
            if (bus.req_valid[owner_q]) begin
                grant[owner_q] = 1'b1;
                grant_idx      = owner_q;
            end
        end else begin
`ifdef TILE_ARB_PRIO0_EN
            if (bus.req_valid[0]) begin
                grant[0]  = 1'b1;
                grant_idx = '0;
            end else if (rr_found) begin
                grant[rr_idx] = 1'b1;
                grant_idx     = rr_idx;
            end
`else
            if (rr_found) begin
                grant[rr_idx] = 1'b1;
                grant_idx     = rr_idx;
            end
`endif
        end
    end

    assign accept_any = |grant;

    always_comb begin : p_next_state
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        lock_cnt_d = lock_cnt_q;
        if (state_q == ST_IDLE) begin
            if (accept_any) begin
`ifdef TILE_ARB_PRIO0_EN
                // The display path does not advance the rotation, so the
                // other requesters keep their turn order around it.
                if (grant_idx != '0)
                    rr_ptr_d = ptr_inc(grant_idx);
`else
                rr_ptr_d = ptr_inc(grant_idx);
`endif
                if (bus.req_lock[grant_idx]) begin
                    state_d    = ST_LOCKED;
                    owner_d    = grant_idx;
                    lock_cnt_d = 4'd15;
                end
            end
        end else begin
            // Release either on an explicit unlock (even if the owner is
            // idle that cycle) or on the acceptance that exhausts the count.
            if (!bus.req_lock[owner_q] || (accept_any && (lock_cnt_q == 4'd0))) begin
                state_d    = ST_IDLE;
                rr_ptr_d   = ptr_inc(owner_q);
                lock_cnt_d = 4'd0;
            end else if (accept_any) begin
                lock_cnt_d = lock_cnt_q - 4'd1;
            end
        end
    end

    // Lookup address comes from whichever requester is being accepted.
    assign sel_tile = bus.req_tile[grant_idx];
    assign sel_x    = bus.req_x[grant_idx];
    assign sel_y    = bus.req_y[grant_idx];

    tile_rom_mux #(
        .NUM_TILES (NUM_TILES)
    ) u_rom (
        .tile_i  (sel_tile),
        .x_i     (sel_x),
        .y_i     (sel_y),
        .color_o (rom_color)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            lock_cnt_q  <= '0;
            rsp_valid_q <= '0;
            rsp_color_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            lock_cnt_q  <= lock_cnt_d;
            rsp_valid_q <= grant;
            if (accept_any)
                rsp_color_q <= rom_color;
        end
    end

    assign bus.req_ready = grant;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_color = rsp_color_q;
    assign busy_lock     = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_tile_fetch_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tile_fetch_arbiter
// Directed scenarios plus randomized traffic, checked every cycle against a
// behavioural model of the arbitration rules and sprite artwork. The DUT is
// built with NUM_TILES=6 so tile ids 6 and 7 read as 0.
// ---------------------------------------------------------------------------
module tb_tile_fetch_arbiter;
    import tile_pkg::*;

    localparam int NR       = 4;
    localparam int TB_TILES = 6;

    logic Clk = 1'b0;
    logic Reset;
    logic busy_lock;

    tile_fetch_arbiter_if #(.NUM_REQ(NR)) bus ();

    tile_fetch_arbiter #(
        .NUM_REQ   (NR),
        .NUM_TILES (TB_TILES)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .bus       (bus),
        .busy_lock (busy_lock)
    );

    always #5 Clk = ~Clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    bit            m_locked;
    int            m_ptr;
    int            m_owner;
    int            m_cnt;
    logic [NR-1:0] exp_rsp_valid;
    int            exp_color;

    logic [NR-1:0] obs_ready;
    logic          obs_busy;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Artwork as drawn: palette index at (x, y) of tile t.
    function automatic int ref_pixel(int t, int x, int y);
        bit rim = (x == 0) || (x == 15) || (y == 0) || (y == 15);
        if (t >= TB_TILES) return 0;
        case (t)
            0: return 0;
            1: begin
                if (y % 4 == 3) return 8;
                if ((y % 8) < 4) return (x % 8 == 7) ? 8 : 9;
                return (x % 8 == 3) ? 8 : 9;
            end
            2: begin
                if (rim) return 4;
                if ((x == 2 || x == 13) && (y == 2 || y == 13)) return 5;
                return (((x / 4) + (y / 4)) % 2 == 1) ? 1 : 2;
            end
            3: return ((x + y) % 4 == 0) ? 13 : 12;
            4: return ((x + y) % 2 == 1) ? 20 : 21;
            5: return (x == y || x + y == 15) ? 30 : 31;
            6: return (x >= 4 && x <= 11 && y >= 4 && y <= 11) ? 40 : 41;
            default: return rim ? 50 : 51;
        endcase
    endfunction

    // Who should be granted now, or -1.
    function automatic int ref_winner();
        if (m_locked) return bus.req_valid[m_owner] ? m_owner : -1;
`ifdef TILE_ARB_PRIO0_EN
        if (bus.req_valid[0]) return 0;
`endif
        for (int k = 0; k < NR; k++) begin
            int c = (m_ptr + k) % NR;
            if (bus.req_valid[c]) return c;
        end
        return -1;
    endfunction

    task automatic ref_update(input int w);
        exp_rsp_valid = '0;
        if (w >= 0) begin
            exp_rsp_valid[w] = 1'b1;
            exp_color = ref_pixel(int'(bus.req_tile[w]), int'(bus.req_x[w]), int'(bus.req_y[w]));
        end
        if (!m_locked) begin
            if (w >= 0) begin
`ifdef TILE_ARB_PRIO0_EN
                if (w != 0) m_ptr = (w + 1) % NR;
`else
                m_ptr = (w + 1) % NR;
`endif
                if (bus.req_lock[w]) begin
                    m_locked = 1'b1;
                    m_owner  = w;
                    m_cnt    = 15;
                end
            end
        end else begin
            if (!bus.req_lock[m_owner] || (w >= 0 && m_cnt == 0)) begin
                m_locked = 1'b0;
                m_ptr    = (m_owner + 1) % NR;
            end else if (w >= 0) begin
                m_cnt--;
            end
        end
    endtask

    // One clock: check at the falling edge, advance the model at the rising
    // edge, return 1 time unit later so new inputs can be driven.
    task automatic step();
        int w;
        logic [NR-1:0] exp_ready;
        @(negedge Clk);
        w = ref_winner();
        exp_ready = '0;
        if (w >= 0) exp_ready[w] = 1'b1;
        obs_ready = bus.req_ready;
        obs_busy  = busy_lock;
        check_val("req_ready", 32'(bus.req_ready), 32'(exp_ready));
        check_val("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rsp_valid));
        check_val("rsp_color", 32'(bus.rsp_color), 32'(exp_color));
        check_val("busy_lock", 32'(busy_lock), 32'(m_locked));
        @(posedge Clk);
        ref_update(w);
        #1;
    endtask

    // Assert reset, check outputs clear at once, hold for two clocks.
    task automatic do_reset();
        Reset = 1'b1;
        #1;
        check_val("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_val("rst_rsp_color", 32'(bus.rsp_color), 32'd0);
        check_val("rst_busy_lock", 32'(busy_lock), 32'd0);
        repeat (2) @(posedge Clk);
        #1;
        Reset         = 1'b0;
        m_locked      = 1'b0;
        m_ptr         = 0;
        m_owner       = 0;
        m_cnt         = 0;
        exp_rsp_valid = '0;
        exp_color     = 0;
    endtask

    task automatic set_req(input int r, input bit v, input bit l, input int t, input int x, input int y);
        bus.req_valid[r] = v;
        bus.req_lock[r]  = l;
        bus.req_tile[r]  = 3'(t);
        bus.req_x[r]     = 4'(x);
        bus.req_y[r]     = 4'(y);
    endtask

    int seq_a [5] = '{0, 1, 2, 3, 0};
    int steel_x [3] = '{7, 0, 2};
    int steel_y [3] = '{1, 0, 2};
    int steel_c [3] = '{1, 4, 5};

    initial begin
        Reset         = 1'b0;
        bus.req_valid = '0;
        bus.req_lock  = '0;
        bus.req_tile  = '0;
        bus.req_x     = '0;
        bus.req_y     = '0;
        m_locked      = 1'b0;
        m_ptr         = 0;
        m_owner       = 0;
        m_cnt         = 0;
        exp_rsp_valid = '0;
        exp_color     = 0;
        #1;
        do_reset();

        // All four valid: plain rotation 0,1,2,3,0, responses one cycle later
        for (int r = 0; r < NR; r++)
            set_req(r, 1'b1, 1'b0, $urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15));
        for (int k = 0; k < 5; k++) begin
            step();
            check_val("rr_grant", 32'(obs_ready), 32'(1) << seq_a[k]);
            check_val("rr_rsp", 32'(bus.rsp_valid), 32'(1) << seq_a[k]);
        end
        bus.req_valid = '0;
        step();
        check_val("idle_no_grant", 32'(obs_ready), 32'd0);
        step();

        // STEEL pixels through requester 2
        for (int k = 0; k < 3; k++) begin
            set_req(2, 1'b1, 1'b0, 2, steel_x[k], steel_y[k]);
            step();
            check_val("steel_color", 32'(bus.rsp_color), 32'(steel_c[k]));
            check_val("steel_rsp", 32'(bus.rsp_valid), 32'h4);
        end
        bus.req_valid = '0;
        step();
        check_val("color_hold", 32'(bus.rsp_color), 32'd5);

        // Requester 1 burst of 16 beats (unlock on the last) against requester 3
        do_reset();
        set_req(3, 1'b1, 1'b0, 4, 3, 3);
        for (int c = 0; c < 16; c++) begin
            set_req(1, 1'b1, (c < 15), $urandom_range(0, 7), c, c);
            step();
            check_val("burst_grant", 32'(obs_ready), 32'h2);
            if (c > 0) check_val("burst_busy", 32'(obs_busy), 32'd1);
        end
        set_req(1, 1'b0, 1'b0, 0, 0, 0);
        step();
        check_val("after_burst", 32'(obs_ready), 32'h8);
        bus.req_valid = '0;
        step();

        // Owner stalls 3 cycles mid-burst; count is preserved
        do_reset();
        set_req(0, 1'b1, 1'b1, 1, 5, 5);
        set_req(1, 1'b1, 1'b0, 3, 4, 0);
        for (int c = 0; c < 4; c++) begin
            step();
            check_val("lock_grant", 32'(obs_ready), 32'h1);
        end
        bus.req_valid[0] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            check_val("stall_grant", 32'(obs_ready), 32'd0);
        end
        bus.req_valid[0] = 1'b1;
        for (int c = 0; c < 13; c++) begin
            step();
            check_val("resume_grant", 32'(obs_ready), 32'h1);
        end
        step();
        check_val("post_lock", 32'(obs_ready), 32'h2);

        // Reset in the middle of a burst at lock_cnt 8
        do_reset();
        bus.req_valid = '0;
        bus.req_lock  = '0;
        set_req(2, 1'b1, 1'b1, 3, 1, 0);
        step();
        for (int r = 0; r < NR; r++) bus.req_valid[r] = 1'b1;
        for (int c = 0; c < 7; c++) step();
        check_val("pre_rst_rsp", 32'(bus.rsp_valid), 32'h4);
        #2;
        do_reset();
        bus.req_lock = '0;
        step();
        check_val("post_rst_grant", 32'(obs_ready), 32'h1);

        // Requesters 0 and 2 continuously valid
        do_reset();
        bus.req_valid = '0;
        set_req(0, 1'b1, 1'b0, 5, 6, 6);
        set_req(2, 1'b1, 1'b0, 6, 8, 8);
        for (int c = 0; c < 6; c++) begin
            step();
`ifdef TILE_ARB_PRIO0_EN
            check_val("prio0_grant", 32'(obs_ready), 32'h1);
`else
            check_val("alt_grant", 32'(obs_ready), (c % 2 == 0) ? 32'h1 : 32'h4);
`endif
        end

        // Randomized traffic with sticky locks
        do_reset();
        bus.req_lock = '0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            for (int r = 0; r < NR; r++) begin
                bus.req_valid[r] = ($urandom_range(0, 9) < 6);
                if ($urandom_range(0, 15) == 0) bus.req_lock[r] = ~bus.req_lock[r];
                bus.req_tile[r] = 3'($urandom_range(0, 7));
                bus.req_x[r]    = 4'($urandom_range(0, 15));
                bus.req_y[r]    = 4'($urandom_range(0, 15));
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tile_fetch_arbiter.md
TILE_FETCH_ARBITER -- requirements
Module: tile_fetch_arbiter

Interface
REQ-001 Parameter: NUM_REQ, default 4, number of requesters sharing the tile-texture lookup (2..8).
REQ-002 Parameter: NUM_TILES, default 8, number of 16x16 tile sprites selectable by tile id.
REQ-003 Port: Clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: Reset  input  1  asynchronous, active-high reset.
REQ-005 Port: req_valid  input  NUM_REQ  per-requester lookup request.
REQ-006 Port: req_lock  input  NUM_REQ  request to hold grant for a row burst.
REQ-007 Port: req_tile  input  NUM_REQ x 3  tile id per requester.
REQ-008 Port: req_x, req_y  input  NUM_REQ x 4 each  pixel column and row within the tile.
REQ-009 Port: req_ready  output  NUM_REQ  one-hot grant; a request is accepted when req_valid[i] and req_ready[i] are both high.
REQ-010 Port: rsp_valid  output  NUM_REQ  one-hot response strobe.
REQ-011 Port: rsp_color  output  6  palette index of the looked-up pixel.
REQ-012 Port: busy_lock  output  1  high while the arbiter is in LOCKED.

Function
REQ-013 At most one bit of req_ready shall be high per cycle; req_ready shall be combinational from req_valid and the current state.
REQ-014 In IDLE, grant goes to the first valid requester at or after rr_ptr, searching upward with modulo-NUM_REQ wrap.
REQ-015 On acceptance by requester g, rr_ptr shall become (g+1) mod NUM_REQ, except while in LOCKED.
REQ-016 Latency: rsp_valid[g] and rsp_color shall be registered and high exactly 1 cycle after acceptance.
REQ-017 rsp_color shall equal the pixel at row req_y, column req_x of sprite req_tile; for tile ids >= NUM_TILES it shall be 0.
REQ-018 Without an acceptance in the preceding cycle, rsp_valid shall be 0 and rsp_color shall hold its last value.
REQ-019 If an accepted request has req_lock high in IDLE, the arbiter shall enter LOCKED with owner=g and lock_cnt=15.
REQ-020 In LOCKED, only the owner may be granted; each owner acceptance decrements lock_cnt.
REQ-021 In LOCKED, the arbiter returns to IDLE and sets rr_ptr=(owner+1) mod NUM_REQ in either of two cases: the owner is accepted with lock_cnt=0, or the owner has req_lock low.
REQ-022 In LOCKED, owner req_valid low with req_lock high shall stall without decrementing lock_cnt; other requesters wait.
REQ-023 No req_valid bits set: no grant, state and rr_ptr unchanged.

Reset
REQ-024 On Reset high, independent of Clk: state=IDLE, rr_ptr=0, lock_cnt=0, owner=0, rsp_valid=0, rsp_color=0, busy_lock=0.
REQ-025 Reset asserted mid-burst shall abandon the burst with no response emitted; the first post-reset grant follows REQ-014 from rr_ptr=0.

Configuration
REQ-026 Macro TILE_ARB_PRIO0_EN: when defined, requester 0 (the display path) shall win any IDLE cycle in which it is valid; rr_ptr updates only on grants to other requesters; LOCKED is still honoured.
REQ-027 Without TILE_ARB_PRIO0_EN, all requesters are pure round-robin per REQ-014.

Structure
REQ-028 Shared package tile_pkg shall hold: the tile id enum (EMPTY, BRICK, STEEL, WATER, TREE, ICE, BASE, BORDER), the TILE_W=16 constant, the 6-bit color typedef, and the arbiter state enum (IDLE, LOCKED).
REQ-029 One sub-module, tile_rom_mux, shall instantiate the per-tile sprite ROMs and select a pixel by tile id, x and y combinationally; the registered output stage lives in tile_fetch_arbiter.

Verification
REQ-030 Requesters 0..3 all valid continuously from reset -> grants 0,1,2,3,0 on consecutive cycles; each rsp_valid follows its grant by 1 cycle.
REQ-031 Requester 2 requests tile STEEL at x=7, y=1 -> rsp_color=1 one cycle later; at x=0, y=0 -> 4; at x=2, y=2 -> 5.
REQ-032 Requester 1 locks with 16 valid cycles while requester 3 is valid -> 16 consecutive grants to 1 and busy_lock high; requester 3 is granted on cycle 17; rr_ptr=2 afterwards.
REQ-033 Lock owner drops req_valid for 3 cycles mid-burst -> no grants to anyone, lock_cnt frozen; the burst resumes with its remaining count.
REQ-034 Reset pulsed for 2 cycles at lock_cnt=8 -> outputs zero immediately; the next grant from all-valid is requester 0.
REQ-035 With TILE_ARB_PRIO0_EN defined, requesters 0 and 2 continuously valid -> requester 0 granted every cycle and requester 2 never granted; with the macro undefined, the two alternate.
